// File: rtl/mu0_reg_scan_chain_if.sv
// Scan-port bundle between the MU0 debug wrapper (register taps plus debugger strobes) and the register scan chain.
interface mu0_reg_scan_chain_if;
    logic [15:0] acc;
    logic [11:0] pc;
    logic [1:0]  flags;
    logic        scan_clk;
    logic        scan_en;
    logic        scan_in;
    logic        scan_out;
    logic [4:0]  bit_count;
    logic        chain_done;

    modport master (
        output acc, pc, flags, scan_clk, scan_en, scan_in,
        input  scan_out, bit_count, chain_done
    );

    modport slave (
        input  acc, pc, flags, scan_clk, scan_en, scan_in,
        output scan_out, bit_count, chain_done
    );
endinterface

// File: rtl/mu0_reg_scan_chain.sv
// MU0 register scan chain: captures {flags, pc, acc} into a 30-bit shadow and shifts it out LSB first on synchronised scan_clk strobes.
// Optional feature MU0_SCAN_IN_EN: use synchronised scan_in as the shift fill bit (otherwise fill is 0).
module mu0_reg_scan_chain #(
    parameter int SYNC_STAGES = 2,
    parameter int CHAIN_LEN   = 30
) (
    input  logic                clk,
    input  logic                nreset,
    mu0_reg_scan_chain_if.slave bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("mu0_reg_scan_chain: SYNC_STAGES must be at least 2");
    end
    if (CHAIN_LEN != 30) begin : g_bad_len
        $error("mu0_reg_scan_chain: CHAIN_LEN must be 30");
    end

    localparam logic [4:0] LAST_COUNT = 5'(CHAIN_LEN);

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        SHIFTING,
        DONE
    } state_t;

    state_t                  state;
    logic [CHAIN_LEN-1:0]    shadow;
    logic                    scan_out_q;
    logic [4:0]              bit_count_q;
    logic                    chain_done_q;

    logic [SYNC_STAGES-1:0]  clk_sync;
    logic [SYNC_STAGES-1:0]  en_sync;
    logic                    clk_prev;
    logic                    scan_event;
    logic                    shift_mode;
    logic                    fill;

    // scan_clk and scan_en share one depth so scan_en lines up with the strobe it qualifies.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            clk_sync <= '0;
            en_sync  <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.scan_clk};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], bus.scan_en};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign scan_event = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign shift_mode = en_sync[SYNC_STAGES-1];

`ifdef MU0_SCAN_IN_EN
    logic [SYNC_STAGES-1:0] in_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_sync <= '0;
        end else begin
            in_sync <= {in_sync[SYNC_STAGES-2:0], bus.scan_in};
        end
    end

    assign fill = in_sync[SYNC_STAGES-1];
`else
    assign fill = 1'b0;
`endif

    // Chain control; shifts arriving before any capture have nothing valid to move, so IDLE drops them.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            shadow       <= '0;
            scan_out_q   <= 1'b0;
            bit_count_q  <= '0;
            chain_done_q <= 1'b0;
        end else begin
            scan_out_q <= shadow[0];
            if (scan_event) begin
                if (!shift_mode) begin
                    shadow       <= {bus.flags, bus.pc, bus.acc};
                    bit_count_q  <= '0;
                    chain_done_q <= 1'b0;
                    state        <= LOADED;
                end else if (state != IDLE) begin
                    shadow <= {fill, shadow[CHAIN_LEN-1:1]};
                    if (bit_count_q != LAST_COUNT) begin
                        bit_count_q <= bit_count_q + 5'd1;
                    end
                    if (bit_count_q == LAST_COUNT - 5'd1) begin
                        state        <= DONE;
                        chain_done_q <= 1'b1;
                    end else if (state == LOADED) begin
                        state <= SHIFTING;
                    end
                end
            end
        end
    end

    assign bus.scan_out   = scan_out_q;
    assign bus.bit_count  = bit_count_q;
    assign bus.chain_done = chain_done_q;

endmodule
